// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding, table entry layout and default contents for the HDMI I2C init sequencer.
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, POWERUP, FETCH, ISSUE, WAIT_XFER, GAP, DELAY, ADVANCE, DONE, FAIL
    } seq_state_t;
    typedef logic [255:0][15:0] table_t;
    localparam logic [7:0] DELAY_MARKER = 8'hFF;
    localparam int REG_LSB = 8;
    localparam int DATA_LSB = 0;
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h39;
    // Unused slots hold zero-length delays so an oversized NUM_ENTRIES is harmless.
    function automatic table_t adv7513_table();
        table_t t;
        t = {256{16'hFF00}};
        t[0] = 16'h4110;
        t[1] = 16'hFF0A;
        t[2] = 16'h9803;
        t[3] = 16'h9AE0;
        t[4] = 16'h9C30;
        t[5] = 16'h9D61;
        t[6] = 16'hA2A4;
        t[7] = 16'hA3A4;
        t[8] = 16'hE0D0;
        t[9] = 16'hF900;
        t[10] = 16'h1500;
        t[11] = 16'h1630;
        t[12] = 16'h1702;
        t[13] = 16'h1846;
        t[14] = 16'hAF06;
        t[15] = 16'hBAA0;
        t[16] = 16'hD6C0;
        return t;
    endfunction
endpackage

// File: rtl/i2c_init_rom.sv
// i2c_init_rom: synchronous-read init table, one cycle of read latency.
module i2c_init_rom
    import i2c_pkg::*;
#(
    parameter table_t TABLE = adv7513_table()
) (
    input  logic        clk,
    input  logic [7:0]  addr,
    output logic [15:0] data
);
    always_ff @(posedge clk) data <= TABLE[addr];
endmodule

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks the init table and issues each register write to the I2C engine,
// honouring delay entries and retrying NACKed writes.
module i2c_init_sequencer
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR             = DEFAULT_DEV_ADDR,
    parameter int unsigned NUM_ENTRIES          = 32,
    parameter int unsigned STARTUP_DELAY_CYCLES = 2_500_000,
    parameter int unsigned DELAY_UNIT_CYCLES    = 25_000,
    parameter int unsigned MAX_RETRIES          = 3,
    parameter int unsigned RETRY_GAP_CYCLES     = 2_500,
    parameter table_t      TABLE                = adv7513_table()
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [6:0] cmd_dev_addr,
    output logic [7:0] cmd_reg_addr,
    output logic [7:0] cmd_data,
    input  logic       xfer_done,
    input  logic       xfer_nack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] entry_idx
);
    localparam int unsigned DELAY_MAX = 255 * DELAY_UNIT_CYCLES;
    localparam int unsigned CNT_MAX_A = STARTUP_DELAY_CYCLES > DELAY_MAX ? STARTUP_DELAY_CYCLES : DELAY_MAX;
    localparam int unsigned CNT_MAX = CNT_MAX_A > RETRY_GAP_CYCLES ? CNT_MAX_A : RETRY_GAP_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int RET_W = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      cnt_next;
    logic [RET_W-1:0] retries;
    logic [7:0]       delay_units;
    logic [7:0]       rom_addr;
    logic [15:0]      rom_q;
    logic [7:0]       rom_reg;
    logic [7:0]       rom_dat;

    // Look one entry ahead while advancing so the ROM word is ready during FETCH.
    assign rom_addr = state == ADVANCE ? entry_idx + 8'd1 : entry_idx;
    assign rom_reg = rom_q[REG_LSB +: 8];
    assign rom_dat = rom_q[DATA_LSB +: 8];
    assign cnt_next = 32'(cnt) + 32'd1;
    assign cmd_dev_addr = DEV_ADDR;

    i2c_init_rom #(.TABLE(TABLE)) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cmd_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            entry_idx    <= '0;
            cmd_reg_addr <= '0;
            cmd_data     <= '0;
            cnt          <= '0;
            retries      <= '0;
            delay_units  <= '0;
        end else begin
            case (state)
                IDLE, DONE, FAIL: if (start) begin
                    state     <= POWERUP;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    error     <= 1'b0;
                    entry_idx <= '0;
                    cnt       <= '0;
                    retries   <= '0;
                end
                POWERUP: if (cnt_next >= STARTUP_DELAY_CYCLES) begin
                    state <= FETCH;
                    cnt   <= '0;
                end else cnt <= cnt_next[CNT_W-1:0];
                FETCH: if (rom_reg == DELAY_MARKER) begin
                    state       <= DELAY;
                    delay_units <= rom_dat;
                end else begin
                    state        <= ISSUE;
                    cmd_valid    <= 1'b1;
                    cmd_reg_addr <= rom_reg;
                    cmd_data     <= rom_dat;
                end
                ISSUE: if (cmd_ready) begin
                    state     <= WAIT_XFER;
                    cmd_valid <= 1'b0;
                end
                WAIT_XFER: if (xfer_done) begin
                    if (!xfer_nack) begin
                        state   <= ADVANCE;
                        retries <= '0;
                    end else if (32'(retries) < MAX_RETRIES) begin
                        state   <= GAP;
                        retries <= retries + 1'b1;
                    end else begin
                        state <= FAIL;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                GAP: if (cnt_next >= RETRY_GAP_CYCLES) begin
                    state     <= ISSUE;
                    cmd_valid <= 1'b1;
                    cnt       <= '0;
                end else cnt <= cnt_next[CNT_W-1:0];
                DELAY: if (cnt_next >= 32'(delay_units) * DELAY_UNIT_CYCLES) begin
                    state <= ADVANCE;
                    cnt   <= '0;
                end else cnt <= cnt_next[CNT_W-1:0];
                ADVANCE: if (entry_idx == 8'(NUM_ENTRIES - 1)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state     <= FETCH;
                    entry_idx <= entry_idx + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: scoreboard bench running a three-entry table against a behavioural I2C engine.
module tb_i2c_init_sequencer;
    import i2c_pkg::*;

    function automatic table_t tb_table();
        table_t t;
        t = '0;
        t[0] = 16'h4110;
        t[1] = 16'hFF03;
        t[2] = 16'h9803;
        return t;
    endfunction

    localparam table_t TB_TABLE = tb_table();

    logic       clk;
    logic       reset;
    logic       start;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg_addr;
    logic [7:0] cmd_data;
    logic       xfer_done;
    logic       xfer_nack;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] entry_idx;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          rst_seen = 1'b1;
    logic [22:0] exp_q[$];
    int          gaps[$];
    int          rises, accepts, dones, first_rise, last_done_cyc, t0;
    int          vcnt, dtimer, ready_delay, nack_left;
    logic [7:0]  nack_reg;
    bit          spur, pend_nack, prev_valid, prev_ready;
    logic [15:0] prev_cmd;

    i2c_init_sequencer #(
        .DEV_ADDR             (7'h39),
        .NUM_ENTRIES          (3),
        .STARTUP_DELAY_CYCLES (10),
        .DELAY_UNIT_CYCLES    (4),
        .MAX_RETRIES          (2),
        .RETRY_GAP_CYCLES     (5),
        .TABLE                (TB_TABLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dev_addr (cmd_dev_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_data     (cmd_data),
        .xfer_done    (xfer_done),
        .xfer_nack    (xfer_nack),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .entry_idx    (entry_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gap_at(input int i);
        return i < gaps.size() ? gaps[i] : -1;
    endfunction

    task automatic new_test(input logic [7:0] nr, input int nl, input int rd, input bit sp);
        nack_reg = nr;
        nack_left = nl;
        ready_delay = rd;
        spur = sp;
        gaps.delete();
        rises = 0;
        accepts = 0;
        dones = 0;
    endtask

    task automatic push_cmd(input logic [7:0] r, input logic [7:0] d);
        exp_q.push_back({7'h39, r, d});
    endtask

    task automatic pulse_start();
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("finish_in_time", n < budget, 1);
    endtask

    task automatic wait_accepts(input int want, input int budget);
        int n = 0;
        while (accepts < want && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", n < budget, 1);
    endtask

    // Engine model: ready after ready_delay cycles of valid, completion pulse 20 cycles after acceptance.
    initial begin
        cmd_ready = 1'b0;
        xfer_done = 1'b0;
        xfer_nack = 1'b0;
        forever begin
            @(negedge clk);
            xfer_done = 1'b0;
            xfer_nack = 1'b0;
            if (rst_seen) begin
                cmd_ready = 1'b0;
                vcnt = 0;
                dtimer = 0;
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (prev_valid && !prev_ready) begin
                    check("valid_held", cmd_valid, 1);
                    check("cmd_stable", {cmd_reg_addr, cmd_data}, prev_cmd);
                end
                if (cmd_valid && !prev_valid) begin
                    if (rises == 0) first_rise = cyc;
                    gaps.push_back(cyc - last_done_cyc);
                    rises++;
                end
                if (dtimer > 0) begin
                    dtimer--;
                    if (dtimer == 0) begin
                        xfer_done = 1'b1;
                        xfer_nack = pend_nack;
                        last_done_cyc = cyc;
                        dones++;
                    end else if (dtimer == 10) xfer_nack = 1'b1;
                end else if (spur && dones == 1 && cyc == last_done_cyc + 6) xfer_done = 1'b1;
                if (cmd_ready) cmd_ready = 1'b0;
                else if (cmd_valid) begin
                    if (vcnt >= ready_delay) begin
                        cmd_ready = 1'b1;
                        vcnt = 0;
                        accepts++;
                        check("sb_nonempty", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) check("cmd", {cmd_dev_addr, cmd_reg_addr, cmd_data}, exp_q.pop_front());
                        pend_nack = cmd_reg_addr == nack_reg && nack_left > 0;
                        if (pend_nack) nack_left--;
                        dtimer = 20;
                    end else vcnt++;
                end
                prev_valid = cmd_valid;
                prev_ready = cmd_ready;
                prev_cmd = {cmd_reg_addr, cmd_data};
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        new_test(8'h00, 0, 2, 1'b0);
        last_done_cyc = 0;
        first_rise = -1;
        repeat (3) @(negedge clk);
        check("rst_valid", cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_idx", entry_idx, 0);
        check("rst_reg", cmd_reg_addr, 0);
        check("rst_data", cmd_data, 0);
        check("rst_dev", cmd_dev_addr, 7'h39);
        reset = 1'b0;
        @(negedge clk);

        new_test(8'h00, 0, 2, 1'b0);
        push_cmd(8'h41, 8'h10);
        push_cmd(8'h98, 8'h03);
        pulse_start();
        check("nom_busy", busy, 1);
        wait_end(600);
        check("nom_latency", first_rise - t0, 12);
        check("nom_delay_gap", gap_at(1), 17);
        check("nom_done", done, 1);
        check("nom_busy_end", busy, 0);
        check("nom_error", error, 0);
        check("nom_accepts", accepts, 2);
        check("nom_drained", exp_q.size(), 0);

        new_test(8'h41, 1, 2, 1'b0);
        push_cmd(8'h41, 8'h10);
        push_cmd(8'h41, 8'h10);
        push_cmd(8'h98, 8'h03);
        pulse_start();
        wait_end(600);
        check("nack1_retry_gap", gap_at(1), 6);
        check("nack1_delay_gap", gap_at(2), 17);
        check("nack1_done", done, 1);
        check("nack1_error", error, 0);
        check("nack1_accepts", accepts, 3);
        check("nack1_drained", exp_q.size(), 0);

        new_test(8'h98, 99, 2, 1'b0);
        push_cmd(8'h41, 8'h10);
        push_cmd(8'h98, 8'h03);
        push_cmd(8'h98, 8'h03);
        push_cmd(8'h98, 8'h03);
        pulse_start();
        wait_end(600);
        check("nackp_error", error, 1);
        check("nackp_done", done, 0);
        check("nackp_busy", busy, 0);
        check("nackp_idx", entry_idx, 2);
        repeat (60) @(negedge clk);
        check("nackp_rises", rises, 4);
        check("nackp_accepts", accepts, 4);
        check("nackp_drained", exp_q.size(), 0);

        new_test(8'h00, 0, 50, 1'b0);
        push_cmd(8'h41, 8'h10);
        push_cmd(8'h98, 8'h03);
        pulse_start();
        wait_end(800);
        check("stall_latency", first_rise - t0, 12);
        check("stall_done", done, 1);
        check("stall_error", error, 0);
        check("stall_accepts", accepts, 2);
        check("stall_rises", rises, 2);
        check("stall_drained", exp_q.size(), 0);

        new_test(8'h00, 0, 2, 1'b0);
        push_cmd(8'h41, 8'h10);
        pulse_start();
        wait_accepts(1, 200);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_valid", cmd_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_idx", entry_idx, 0);
        repeat (40) @(negedge clk);
        check("mid_rst_quiet", rises, 1);
        check("mid_rst_drained", exp_q.size(), 0);
        new_test(8'h00, 0, 2, 1'b0);
        push_cmd(8'h41, 8'h10);
        push_cmd(8'h98, 8'h03);
        pulse_start();
        wait_end(600);
        check("rerun_latency", first_rise - t0, 12);
        check("rerun_done", done, 1);
        check("rerun_accepts", accepts, 2);
        check("rerun_drained", exp_q.size(), 0);

        new_test(8'h00, 0, 2, 1'b1);
        push_cmd(8'h41, 8'h10);
        push_cmd(8'h98, 8'h03);
        pulse_start();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_accepts(1, 200);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(600);
        check("spur_latency", first_rise - t0, 12);
        check("spur_delay_gap", gap_at(1), 17);
        check("spur_done", done, 1);
        check("spur_error", error, 0);
        check("spur_accepts", accepts, 2);
        check("spur_rises", rises, 2);
        check("spur_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
